final_adder_pipe: RTL and testbench

FINAL_ADDER_PIPE -- requirements
Module: final_adder_pipe

---
 rtl/final_adder_pipe_pkg.sv | 12 +
 rtl/rca_w.sv | 24 ++
 rtl/final_adder_pipe.sv | 101 ++++++++++
 tb/tb_final_adder_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/final_adder_pipe_pkg.sv
// Shared constants and the full-adder counter cell for the multiplier's final adder.
package final_adder_pipe_pkg;

  localparam int unsigned W_DEFAULT = 8;
  localparam int unsigned OCC_W     = 2;

  // 3:2 counter cell: returns {carry, sum}.
  function automatic logic [1:0] fa_cell(input logic a, input logic b, input logic c);
    return {(a & b) | (a & c) | (b & c), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/rca_w.sv
// W-bit ripple-carry adder with carry-in and carry-out, one counter cell per bit.
module rca_w
  import final_adder_pipe_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign {c[i+1], sum[i]} = fa_cell(a[i], b[i], c[i]);
  end

  assign cout = c[W];

endmodule

// File: rtl/final_adder_pipe.sv
// Two-stage pipelined final adder: low half in stage 1, high half plus carry in stage 2,
// with valid/ready flow control and an occupancy count.
module final_adder_pipe
  import final_adder_pipe_pkg::*;
#(
  parameter int unsigned W = W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*W-1:0]   in_sum,
  input  logic [2*W-1:0]   in_carry,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*W-1:0]   out_prod,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OCC_W-1:0] occupancy
);

  logic         s1_valid;
  logic [W-1:0] s1_lo;
  logic         s1_c;
  logic [W-1:0] s1_hi_sum;
  logic [W-1:0] s1_hi_carry;

  logic         s2_valid;
  logic [W-1:0] s2_lo;
  logic [W-1:0] s2_hi;
  logic         s2_ovf;

  logic [W-1:0] lo_sum;
  logic         lo_c;
  logic [W-1:0] hi_sum;
  logic         hi_c;

  logic s1_advance;
  logic s2_advance;
  logic in_xfer;

  rca_w #(.W(W)) u_rca_lo (
    .a    (in_sum[W-1:0]),
    .b    (in_carry[W-1:0]),
    .cin  (1'b0),
    .sum  (lo_sum),
    .cout (lo_c)
  );

  rca_w #(.W(W)) u_rca_hi (
    .a    (s1_hi_sum),
    .b    (s1_hi_carry),
    .cin  (s1_c),
    .sum  (hi_sum),
    .cout (hi_c)
  );

  // A stage advances when its successor is empty or draining this cycle.
  assign s2_advance = !s2_valid || out_ready;
  assign s1_advance = s2_advance;
  assign in_ready   = !rst && (!s1_valid || s1_advance);
  assign in_xfer    = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_lo       <= '0;
      s1_c        <= 1'b0;
      s1_hi_sum   <= '0;
      s1_hi_carry <= '0;
      s2_valid    <= 1'b0;
      s2_lo       <= '0;
      s2_hi       <= '0;
      s2_ovf      <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
      end
      if (in_xfer) begin
        s1_lo       <= lo_sum;
        s1_c        <= lo_c;
        s1_hi_sum   <= in_sum[2*W-1:W];
        s1_hi_carry <= in_carry[2*W-1:W];
      end
      if (s2_advance) begin
        s2_valid <= s1_valid;
      end
      // Bubbles leave the data registers untouched.
      if (s2_advance && s1_valid) begin
        s2_lo  <= s1_lo;
        s2_hi  <= hi_sum;
        s2_ovf <= hi_c;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_prod  = {s2_hi, s2_lo};
  assign out_ovf   = s2_ovf;
  assign occupancy = OCC_W'(s1_valid) + OCC_W'(s2_valid);

endmodule

// File: tb/tb_final_adder_pipe.sv
// Randomized self-checking bench for final_adder_pipe against a queue-based sum model.
module tb_final_adder_pipe;

  localparam int unsigned W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [2*W-1:0] in_sum = '0;
  logic [2*W-1:0] in_carry = '0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*W-1:0] out_prod;
  logic           out_ovf;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [1:0]     occupancy;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [2*W:0] exp_q[$];
  logic         stall_prev = 1'b0;
  logic [2*W:0] held = '0;
  logic         last_in_xfer = 1'b0;

  final_adder_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_sum    (in_sum),
    .in_carry  (in_carry),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_prod  (out_prod),
    .out_ovf   (out_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample handshakes mid-cycle, update scoreboard, advance past the edge.
  task automatic step();
    logic ix;
    logic ox;
    logic [2*W:0] e;
    #1;
    ix = in_valid && in_ready;
    ox = out_valid && out_ready;
    if (stall_prev) begin
      check("hold_prod", 32'({out_ovf, out_prod}), 32'(held));
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    if (ox) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'({out_ovf, out_prod}), 32'(e));
      end
    end
    if (ix) exp_q.push_back({1'b0, in_sum} + {1'b0, in_carry});
    stall_prev   = out_valid && !out_ready;
    held         = {out_ovf, out_prod};
    last_in_xfer = ix;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < max_cycles) begin
      step();
      n++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic single(input logic [2*W-1:0] s, input logic [2*W-1:0] c,
                        input logic [2*W:0] want);
    out_ready = 1'b1;
    in_sum    = s;
    in_carry  = c;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    check("lat_one_cycle", 32'(out_valid), 32'd0);
    step();
    check("lat_two_cycle", 32'(out_valid), 32'd1);
    check("direct_value", 32'({out_ovf, out_prod}), 32'(want));
    drain(10);
  endtask

  initial begin
    // Reset values while rst is held
    #3;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_out_prod", 32'(out_prod), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    single(16'h00FF, 16'h0001, 17'h00100);
    single(16'hFFFF, 16'h0001, 17'h10000);

    // Backpressure: three inputs with the consumer stalled
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_sum   = 16'(k);
      in_carry = 16'(k);
      in_valid = 1'b1;
      if (k < 3) step();
    end
    #1;
    check("bp_occupancy", 32'(occupancy), 32'd2);
    check("bp_in_ready", 32'(in_ready), 32'd0);
    step();
    check("bp_held_ready", 32'(in_ready), 32'd0);
    check("bp_held_out", 32'({out_ovf, out_prod}), 32'd2);
    out_ready = 1'b1;
    #1;
    check("bp_ready_rise", 32'(in_ready), 32'd1);
    step();
    check("bp_third_taken", 32'(last_in_xfer), 32'd1);
    check("bp_occ_full_xfer", 32'(occupancy), 32'd2);
    in_valid = 1'b0;
    drain(10);

    // Streaming: one result per cycle once full
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_sum   = 16'($urandom);
      in_carry = 16'($urandom);
      in_valid = 1'b1;
      #1;
      if (i >= 2) check("stream_valid", 32'(out_valid), 32'd1);
      step();
    end
    drain(10);

    // Reset mid-flight
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_sum   = 16'h1234 + 16'(k);
      in_carry = 16'h0101;
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("mid_occ_full", 32'(occupancy), 32'd2);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_occ", 32'(occupancy), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    single(16'h0F0F, 16'h0101, 17'h01010);
    for (int k = 0; k < 4; k++) step();

    // Random valid/ready toggling with scoreboard and stall-hold checks
    for (int i = 0; i < 400; i++) begin
      in_sum    = 16'($urandom);
      in_carry  = 16'($urandom);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    drain(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
